// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: integer+fraction clock divider to an
// oversample tick, then a fixed OSR divider to mid-bit and bit ticks.
module baud_gen_frac #(
  parameter int               DIV_W    = 16,
  parameter int               FRAC_W   = 4,
  parameter int               OSR      = 16,
  parameter logic [DIV_W-1:0] RST_DIV  = 16'd651,
  parameter logic [FRAC_W-1:0] RST_FRAC = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_pending,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OSC_W = $clog2(OSR);
  localparam logic [OSC_W-1:0] OSC_MAX = OSC_W'(OSR - 1);
  localparam logic [OSC_W-1:0] OSC_MID = OSC_W'(OSR / 2 - 1);

  // one extra bit so a maximal divisor plus the carry cycle is reachable
  logic [DIV_W:0]    cnt;
  logic [DIV_W:0]    ei;
  logic [DIV_W:0]    last;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [OSC_W-1:0]  osc;
  logic [DIV_W-1:0]  ai;
  logic [DIV_W-1:0]  si;
  logic [FRAC_W-1:0] af;
  logic [FRAC_W-1:0] sf;
  logic              pend;
  logic [FRAC_W:0]   sum;
  logic              run;
  logic              ev;
  logic              bnd;
  logic              apply;

  always_comb begin
    ei    = (ai < DIV_W'(2)) ? (DIV_W+1)'(2) : {1'b0, ai};
    last  = ei - (DIV_W+1)'(1) + (DIV_W+1)'(ext);
    run   = en & ~restart;
    ev    = run & (cnt == last);
    bnd   = ev & (osc == OSC_MAX);
    apply = pend & (bnd | ~en | restart);
    sum   = {1'b0, acc} + {1'b0, af};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
      osc <= '0;
    end else if (restart) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
      osc <= '0;
    end else if (ev) begin
      cnt <= '0;
      acc <= sum[FRAC_W-1:0];
      ext <= sum[FRAC_W];
      osc <= (osc == OSC_MAX) ? '0 : osc + OSC_W'(1);
    end else if (en) begin
      cnt <= cnt + (DIV_W+1)'(1);
    end
  end

  // a load coinciding with an apply stays pending for the next boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai   <= RST_DIV;
      af   <= RST_FRAC;
      si   <= RST_DIV;
      sf   <= RST_FRAC;
      pend <= 1'b0;
    end else begin
      if (apply) begin
        ai <= si;
        af <= sf;
      end
      if (div_load) begin
        si   <= div_int;
        sf   <= div_frac;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= ev;
      mid_tick <= ev & (osc == OSC_MID);
      bit_tick <= bnd;
    end
  end

  assign div_pending = pend;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed steps plus random traffic checked
// every cycle against a tick-schedule model.
module tb_baud_gen_frac;

  localparam int OSR = 16;
  localparam int FS  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_pending;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;

  int n_assert = 0;
  int n_fail = 0;

  // model: absolute cycle of the next os event, tick index, residual
  int m_cyc, m_nxt, m_k, m_res;
  int m_ai, m_af, m_si, m_sf;
  bit m_pend;
  bit e_os, e_mid, e_bit;

  int first_os, first_mid, last_os;
  int bit_last, bit_gap, os_since, os_per_bit;
  bit ok;

  always #5 clk = ~clk;

  baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OSR(OSR),
    .RST_DIV(16'd651), .RST_FRAC(4'd0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .div_pending(div_pending),
    .os_tick(os_tick), .mid_tick(mid_tick),
    .bit_tick(bit_tick)
  );

  function automatic int eff(int a);
    return (a < 2) ? 2 : a;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ai = 651; m_si = 651; m_af = 0; m_sf = 0;
    m_pend = 0; m_k = 0; m_res = 0;
    m_cyc = 0; m_nxt = eff(651) - 1;
    e_os = 0; e_mid = 0; e_bit = 0;
  endtask

  task automatic m_step(bit e, bit r, bit ld, int di, int df);
    bit ev;
    bit bnd;
    int carry;
    int old_ei;
    bnd = 0; carry = 0;
    old_ei = eff(m_ai);
    e_os = 0; e_mid = 0; e_bit = 0;
    ev = !r && e && (m_cyc == m_nxt);
    if (ev) begin
      e_os = 1;
      e_mid = (m_k == OSR / 2 - 1);
      e_bit = (m_k == OSR - 1);
      bnd = e_bit;
      m_res = m_res + m_af;
      carry = (m_res >= FS) ? 1 : 0;
      m_res = m_res % FS;
      m_k = (m_k + 1) % OSR;
    end
    if (m_pend && (bnd || !e || r)) begin
      m_ai = m_si; m_af = m_sf; m_pend = 0;
    end
    if (ld) begin
      m_si = di; m_sf = df; m_pend = 1;
    end
    if (r) begin
      m_k = 0; m_res = 0;
      m_nxt = m_cyc + eff(m_ai);
    end else if (ev) begin
      m_nxt = m_cyc + eff(m_ai) + carry;
    end else if (!e) begin
      m_nxt = m_nxt + 1 + eff(m_ai) - old_ei;
    end
    m_cyc++;
  endtask

  task automatic step(bit e, bit r, bit ld, int di, int df);
    en = e; restart = r; div_load = ld;
    div_int = di[15:0]; div_frac = df[3:0];
    m_step(e, r, ld, di, df);
    @(posedge clk);
    #1;
    chk("os_tick", {31'b0, os_tick}, {31'b0, e_os});
    chk("mid_tick", {31'b0, mid_tick}, {31'b0, e_mid});
    chk("bit_tick", {31'b0, bit_tick}, {31'b0, e_bit});
    chk("div_pending", {31'b0, div_pending}, {31'b0, m_pend});
    if (os_tick) begin
      if (first_os < 0) first_os = m_cyc;
      last_os = m_cyc;
      os_since++;
    end
    if (mid_tick && first_mid < 0) first_mid = m_cyc;
    if (bit_tick) begin
      bit_gap = m_cyc - bit_last;
      bit_last = m_cyc;
      os_per_bit = os_since;
      os_since = 0;
    end
  endtask

  task automatic run(int n);
    repeat (n) step(1, 0, 0, 0, 0);
  endtask

  task automatic wait_os(int max, output bit got);
    got = 0;
    for (int i = 0; i < max && !got; i++) begin
      step(1, 0, 0, 0, 0);
      got = os_tick;
    end
    if (!got) chk("wait_os_timeout", 0, 1);
  endtask

  task automatic reprogram(int di, int df);
    step(1, 0, 1, di, df);
    step(1, 1, 0, 0, 0);
  endtask

  initial begin
    int t;
    bit e, r, ld;
    first_os = -1; first_mid = -1; last_os = 0;
    bit_last = 0; bit_gap = 0; os_since = 0; os_per_bit = 0;
    m_reset();
    #1;
    chk("rst_os", {31'b0, os_tick}, 0);
    chk("rst_mid", {31'b0, mid_tick}, 0);
    chk("rst_bit", {31'b0, bit_tick}, 0);
    chk("rst_pend", {31'b0, div_pending}, 0);
    @(posedge clk); #1;
    rst = 0;

    run(660);
    chk("first_os_rst_div", first_os, 651);

    step(1, 0, 1, 4, 0);
    chk("pend_after_load", {31'b0, div_pending}, 1);
    step(1, 1, 0, 0, 0);
    run(200);
    chk("bit_gap_div4", bit_gap, 64);
    chk("os_per_bit_div4", os_per_bit, 16);

    reprogram(4, 4);
    run(300);
    chk("bit_gap_frac4", bit_gap, 68);
    chk("os_per_bit_frac4", os_per_bit, 16);

    reprogram(4, 8);
    run(300);
    chk("bit_gap_frac8", bit_gap, 72);

    reprogram(4, 0);
    run(20);
    step(1, 0, 1, 7, 0);
    run(3);
    step(1, 0, 1, 10, 0);
    run(400);
    chk("bit_gap_div10", bit_gap, 160);
    chk("pend_cleared", {31'b0, div_pending}, 0);

    run(13);
    t = m_cyc;
    step(1, 1, 0, 0, 0);
    chk("restart_quiet", {31'b0, os_tick}, 0);
    first_os = -1; first_mid = -1;
    run(100);
    chk("restart_first_os", first_os, t + 1 + 10);
    chk("restart_first_mid", first_mid, t + 10 * OSR / 2 + 1);

    for (int i = 0; i < 40 && m_nxt != m_cyc; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("restart_on_event", {31'b0, os_tick}, 0);

    wait_os(40, ok);
    t = last_os;
    run(3);
    repeat (7) step(0, 0, 0, 0, 0);
    wait_os(40, ok);
    chk("en_low_gap", last_os - t, 17);

    reprogram(0, 0);
    run(100);
    chk("bit_gap_div0", bit_gap, 32);
    reprogram(1, 0);
    run(100);
    chk("bit_gap_div1", bit_gap, 32);

    for (int i = 0; i < 3000; i++) begin
      e = m_pend ? 1'b1 : ($urandom_range(9) != 0);
      r = ($urandom_range(99) == 0);
      ld = e && ($urandom_range(149) == 0);
      step(e, r, ld, int'($urandom_range(12)), int'($urandom_range(15)));
    end

    reprogram(5, 0);
    run(30);
    step(1, 0, 1, 9, 0);
    wait_os(20, ok);
    #2 rst = 1;
    #1;
    chk("async_rst_os", {31'b0, os_tick}, 0);
    chk("async_rst_pend", {31'b0, div_pending}, 0);
    @(posedge clk); #1;
    m_reset();
    rst = 0;
    first_os = -1;
    run(660);
    chk("rst_div_restored", first_os, 651);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
